// File: rtl/alu_seq_pkg.sv
// Shared definitions for the alu_seq front end: ALU command codes, sequencer
// state encoding and a shift-command helper.
package alu_seq_pkg;

    localparam int DW = 16;
    localparam int CW = 3;

    localparam logic [CW-1:0] ALU_THA = 3'd0;
    localparam logic [CW-1:0] ALU_THB = 3'd1;
    localparam logic [CW-1:0] ALU_AND = 3'd2;
    localparam logic [CW-1:0] ALU_OR  = 3'd3;
    localparam logic [CW-1:0] ALU_SL  = 3'd4;
    localparam logic [CW-1:0] ALU_SR  = 3'd5;
    localparam logic [CW-1:0] ALU_ADD = 3'd6;
    localparam logic [CW-1:0] ALU_SUB = 3'd7;

    typedef enum logic [1:0] {
        ALU_SEQ_IDLE = 2'd0,
        ALU_SEQ_EXEC = 2'd1,
        ALU_SEQ_RESP = 2'd2
    } alu_seq_state_e;

    function automatic logic is_shift(input logic [CW-1:0] com);
        return (com == ALU_SL) || (com == ALU_SR);
    endfunction

endpackage

// File: rtl/alu.sv
// POCO combinational 16-bit ALU; shifts move a single bit per evaluation.
module alu
    import alu_seq_pkg::*;
(
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic [2:0]  com,
    output logic [15:0] y
);

    always_comb begin
        y = a;
        case (com)
            ALU_THA: y = a;
            ALU_THB: y = b;
            ALU_AND: y = a & b;
            ALU_OR:  y = a | b;
            ALU_SL:  y = {a[14:0], 1'b0};
            ALU_SR:  y = {1'b0, a[15:1]};
            ALU_ADD: y = a + b;
            ALU_SUB: y = a - b;
            default: y = a;
        endcase
    end

endmodule

// File: rtl/alu_seq.sv
// Request/response sequencer around the POCO alu; multi-bit shifts iterate 1-bit passes.
// Define ALU_SEQ_FLAGS_EN to build the zero and carry/borrow/shift-out flags.
module alu_seq
    import alu_seq_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_com,
    input  logic [15:0] req_a,
    input  logic [15:0] req_b,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_y,
    output logic        rsp_z,
    output logic        rsp_c
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both high; rsp_y/rsp_z/rsp_c stay stable while rsp_valid waits for rsp_ready.
    alu_seq_state_e state_q, state_d;
    logic [15:0]    acc_q, acc_d;
    logic [15:0]    opb_q, opb_d;
    logic [2:0]     com_q, com_d;
    logic [3:0]     cnt_q, cnt_d;
    logic [15:0]    rsp_y_q, rsp_y_d;
    logic [15:0]    alu_y;
    logic           accept;
    logic           shift_op;
    logic           shifting;

    alu u_alu (
        .a   (acc_q),
        .b   (opb_q),
        .com (com_q),
        .y   (alu_y)
    );

    assign accept   = req_valid && req_ready;
    assign shift_op = is_shift(com_q);
    assign shifting = shift_op && (cnt_q != 4'd0);

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= ALU_SEQ_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ALU_SEQ_IDLE: if (accept)    state_d = ALU_SEQ_EXEC;
            ALU_SEQ_EXEC: if (!shifting) state_d = ALU_SEQ_RESP;
            ALU_SEQ_RESP: if (rsp_ready) state_d = ALU_SEQ_IDLE;
            default:                     state_d = ALU_SEQ_IDLE;
        endcase
    end

    always_comb begin
        req_ready = rst_n && (state_q == ALU_SEQ_IDLE);
        rsp_valid = (state_q == ALU_SEQ_RESP);
    end

    always_comb begin
        acc_d   = acc_q;
        opb_d   = opb_q;
        com_d   = com_q;
        cnt_d   = cnt_q;
        rsp_y_d = rsp_y_q;
        if (state_q == ALU_SEQ_IDLE && accept) begin
            acc_d = req_a;
            opb_d = req_b;
            com_d = req_com;
            cnt_d = is_shift(req_com) ? req_b[3:0] : 4'd0;
        end else if (state_q == ALU_SEQ_EXEC) begin
            if (shifting) begin
                acc_d = alu_y;
                cnt_d = cnt_q - 4'd1;
            end else begin
                // alu_y holds one extra shift for shift commands, so take acc directly
                rsp_y_d = shift_op ? acc_q : alu_y;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q   <= '0;
            opb_q   <= '0;
            com_q   <= ALU_THA;
            cnt_q   <= '0;
            rsp_y_q <= '0;
        end else begin
            acc_q   <= acc_d;
            opb_q   <= opb_d;
            com_q   <= com_d;
            cnt_q   <= cnt_d;
            rsp_y_q <= rsp_y_d;
        end
    end

    assign rsp_y = rsp_y_q;

`ifdef ALU_SEQ_FLAGS_EN
    logic        c_q, c_d;
    logic        rsp_z_q, rsp_z_d;
    logic        rsp_c_q, rsp_c_d;
    logic [16:0] sum17;

    assign sum17 = {1'b0, acc_q} + {1'b0, opb_q};

    always_comb begin
        c_d     = c_q;
        rsp_z_d = rsp_z_q;
        rsp_c_d = rsp_c_q;
        if (state_q == ALU_SEQ_IDLE && accept) begin
            c_d = 1'b0;
        end else if (state_q == ALU_SEQ_EXEC) begin
            if (shifting) begin
                c_d = (com_q == ALU_SL) ? acc_q[15] : acc_q[0];
            end else begin
                rsp_z_d = shift_op ? (acc_q == 16'd0) : (alu_y == 16'd0);
                case (com_q)
                    ALU_ADD:        rsp_c_d = sum17[16];
                    ALU_SUB:        rsp_c_d = (acc_q < opb_q);
                    ALU_SL, ALU_SR: rsp_c_d = c_q;
                    default:        rsp_c_d = 1'b0;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            c_q     <= 1'b0;
            rsp_z_q <= 1'b0;
            rsp_c_q <= 1'b0;
        end else begin
            c_q     <= c_d;
            rsp_z_q <= rsp_z_d;
            rsp_c_q <= rsp_c_d;
        end
    end

    assign rsp_z = rsp_z_q;
    assign rsp_c = rsp_c_q;
`else
    assign rsp_z = 1'b0;
    assign rsp_c = 1'b0;
`endif

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: hand-computed vectors, latency, backpressure and reset.
// Expected flags follow ALU_SEQ_FLAGS_EN as seen by this compile.
module tb_alu_seq;
    import alu_seq_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_com;
    logic [15:0] req_a;
    logic [15:0] req_b;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_y;
    logic        rsp_z;
    logic        rsp_c;

    int pass_cnt  = 0;
    int total_cnt = 0;
    logic [17:0] exp_q[$];

    alu_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_com   (req_com),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_y     (rsp_y),
        .rsp_z     (rsp_z),
        .rsp_c     (rsp_c)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        assert (got === exp) pass_cnt++;
        else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic push_exp(input logic [15:0] y, input logic z, input logic c);
`ifdef ALU_SEQ_FLAGS_EN
        exp_q.push_back({z, c, y});
`else
        exp_q.push_back({2'b00, y});
`endif
    endtask

    // Drives one command and returns just after the accepting edge.
    task automatic send(input logic [2:0] com, input logic [15:0] a, input logic [15:0] b);
        int n;
        @(negedge clk);
        req_valid = 1'b1;
        req_com   = com;
        req_a     = a;
        req_b     = b;
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) check("send_ready_timeout", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_com   = 3'($urandom_range(0, 7));
        req_a     = 16'($urandom_range(0, 65535));
        req_b     = 16'($urandom_range(0, 65535));
    endtask

    // Waits for the response, checks latency and payload, then consumes it.
    task automatic recv(input string tag, input int k);
        int n;
        logic [17:0] e;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!rsp_valid && n < 40);
        check({tag, "_lat"}, 32'(n - 1), 32'(k + 1));
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 18'h3ffff;
        check({tag, "_y"}, 32'(rsp_y), 32'(e[15:0]));
        check({tag, "_z"}, 32'(rsp_z), 32'(e[17]));
        check({tag, "_c"}, 32'(rsp_c), 32'(e[16]));
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        @(negedge clk);
        check({tag, "_done_valid"}, 32'(rsp_valid), 32'd0);
        check({tag, "_done_ready"}, 32'(req_ready), 32'd1);
    endtask

    initial begin
        int n;
        logic [17:0] e;
        logic seen;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_com   = ALU_THA;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_valid", 32'(rsp_valid), 32'd0);
        check("rst_y", 32'(rsp_y), 32'd0);
        check("rst_zc", 32'({rsp_z, rsp_c}), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_release_ready", 32'(req_ready), 32'd1);

        send(ALU_ADD, 16'hFFFE, 16'h0001); push_exp(16'hFFFF, 1'b0, 1'b0); recv("add0", 0);
        send(ALU_ADD, 16'hFFFF, 16'h0001); push_exp(16'h0000, 1'b1, 1'b1); recv("add_carry", 0);
        send(ALU_SUB, 16'hFFF1, 16'h0001); push_exp(16'hFFF0, 1'b0, 1'b0); recv("sub0", 0);
        send(ALU_SUB, 16'h0001, 16'h0002); push_exp(16'hFFFF, 1'b0, 1'b1); recv("sub_borrow", 0);
        send(ALU_SL,  16'h0008, 16'h0003); push_exp(16'h0040, 1'b0, 1'b0); recv("sl3", 3);
        send(ALU_SR,  16'h0001, 16'h0001); push_exp(16'h0000, 1'b1, 1'b1); recv("sr1", 1);
        send(ALU_SL,  16'h1234, 16'h0000); push_exp(16'h1234, 1'b0, 1'b0); recv("sl0", 0);
        send(ALU_SL,  16'h8001, 16'h0011); push_exp(16'h0002, 1'b0, 1'b1); recv("sl_kmask", 1);
        send(ALU_SR,  16'h8000, 16'h000F); push_exp(16'h0001, 1'b0, 1'b0); recv("sr15", 15);
        send(ALU_AND, 16'hFF00, 16'hAAAA); push_exp(16'hAA00, 1'b0, 1'b0); recv("and", 0);
        send(ALU_OR,  16'hFF00, 16'hF0F0); push_exp(16'hFFF0, 1'b0, 1'b0); recv("or", 0);
        send(ALU_THA, 16'hFFFF, 16'h1234); push_exp(16'hFFFF, 1'b0, 1'b0); recv("tha", 0);
        send(ALU_THB, 16'h0000, 16'hFFFF); push_exp(16'hFFFF, 1'b0, 1'b0); recv("thb", 0);

        // backpressure: result held while a new command waits unaccepted
        send(ALU_ADD, 16'h0003, 16'h0004); push_exp(16'h0007, 1'b0, 1'b0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!rsp_valid && n < 40);
        check("bp_lat", 32'(n - 1), 32'd1);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 18'h3ffff;
        req_valid = 1'b1;
        req_com   = ALU_AND;
        req_a     = 16'h1234;
        req_b     = 16'h00FF;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_hold_y", 32'(rsp_y), 32'(e[15:0]));
            check("bp_hold_valid", 32'(rsp_valid), 32'd1);
            check("bp_hold_ready", 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        @(negedge clk);
        check("bp_idle_ready", 32'(req_ready), 32'd1);
        check("bp_idle_valid", 32'(rsp_valid), 32'd0);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_a     = 16'hFFFF;
        push_exp(16'h0034, 1'b0, 1'b0);
        recv("bp_next", 0);

        // consumer already ready when the response appears
        rsp_ready = 1'b1;
        send(ALU_OR, 16'h0F0F, 16'h00F0);
        @(negedge clk);
        check("sc_pre_valid", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        check("sc_valid", 32'(rsp_valid), 32'd1);
        check("sc_y", 32'(rsp_y), 32'h0FFF);
        @(negedge clk);
        check("sc_done_valid", 32'(rsp_valid), 32'd0);
        check("sc_done_ready", 32'(req_ready), 32'd1);
        rsp_ready = 1'b0;

        // reset in the middle of a long shift
        send(ALU_SL, 16'hFFFF, 16'h000F);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_rst_ready", 32'(req_ready), 32'd0);
        check("mid_rst_valid", 32'(rsp_valid), 32'd0);
        check("mid_rst_y", 32'(rsp_y), 32'd0);
        check("mid_rst_zc", 32'({rsp_z, rsp_c}), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("mid_rst_release_ready", 32'(req_ready), 32'd1);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rsp_valid) seen = 1'b1;
        end
        check("mid_rst_no_rsp", 32'(seen), 32'd0);

        send(ALU_ADD, 16'hFFFF, 16'h0001); push_exp(16'h0000, 1'b1, 1'b1); recv("add_after_rst", 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
